// File: rtl/acc_sequencer_if.sv
// Command handshake bundle for acc_sequencer: one op + operand transfers per
// cmd_valid & cmd_ready at the rising clock edge.
interface acc_sequencer_if #(
  parameter int WIDTH = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_operand;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_operand,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_operand,
    output cmd_ready
  );
endinterface

// File: rtl/acc_sequencer.sv
// Accumulator/issue stage feeding an external WIDTH-bit ALU (IDLE -> ISSUE -> WB).
// Optional ACC_SEQ_ZFLAG_EN adds a registered zero_flag tracking acc == 0.
module acc_sequencer #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] ACC_RESET = '0
) (
  input  logic             clk,
  input  logic             reset,
  acc_sequencer_if.slave   cmd,
  output logic [WIDTH-1:0] alu_acc,
  output logic [WIDTH-1:0] alu_data,
  output logic [1:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_result,
  output logic [WIDTH-1:0] acc,
`ifdef ACC_SEQ_ZFLAG_EN
  output logic             zero_flag,
`endif
  output logic             branch_taken,
  output logic             done,
  output logic             illegal_op
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WB    = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_NAND = 3'd1,
    OP_BNE  = 3'd2,
    OP_SLT  = 3'd3,
    OP_LDA  = 3'd4,
    OP_NOP  = 3'd5
  } op_e;

  localparam logic [1:0] CTRL_BNE = 2'd2;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] alu_acc_q, alu_acc_d;
  logic [WIDTH-1:0] alu_data_q, alu_data_d;
  logic [1:0]       alu_ctrl_q, alu_ctrl_d;
  logic             branch_taken_q, branch_taken_d;
  logic             done_q, done_d;
  logic             done_pend_q, done_pend_d;
  logic             illegal_op_q, illegal_op_d;
  logic             acc_we;
  logic             accept;

  // Ready is masked by reset so nothing is accepted while reset is held.
  assign cmd.cmd_ready = !reset && ((state_q == ST_IDLE) || (state_q == ST_WB));
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;

  // NOTE: every variable gets a default before any branch, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d        = state_q;
    acc_d          = acc_q;
    acc_we         = 1'b0;
    alu_acc_d      = alu_acc_q;
    alu_data_d     = alu_data_q;
    alu_ctrl_d     = alu_ctrl_q;
    branch_taken_d = 1'b0;
    done_d         = done_pend_q;
    done_pend_d    = 1'b0;
    illegal_op_d   = 1'b0;

    unique case (state_q)
      ST_IDLE:  state_d = ST_IDLE;
      ST_ISSUE: state_d = ST_WB;
      ST_WB: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        if (alu_ctrl_q == CTRL_BNE) begin
          branch_taken_d = |alu_result;
        end else begin
          acc_d  = alu_result;
          acc_we = 1'b1;
        end
      end
      default:  state_d = ST_IDLE;
    endcase

    // A command taken in WB sees acc_d, i.e. the value just written back.
    if (accept) begin
      case (cmd.cmd_op)
        OP_ADD, OP_NAND, OP_BNE, OP_SLT: begin
          alu_acc_d  = acc_d;
          alu_data_d = cmd.cmd_operand;
          alu_ctrl_d = cmd.cmd_op[1:0];
          state_d    = ST_ISSUE;
        end
        OP_LDA, OP_NOP: begin
          if (cmd.cmd_op == OP_LDA) begin
            acc_d  = cmd.cmd_operand;
            acc_we = 1'b1;
          end
          // WB retirement already owns this cycle's done; queue a second pulse.
          if (state_q == ST_WB) done_pend_d = 1'b1;
          else                  done_d      = 1'b1;
        end
        default: illegal_op_d = 1'b1;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update
  // together from values sampled before the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      acc_q          <= ACC_RESET;
      alu_acc_q      <= '0;
      alu_data_q     <= '0;
      alu_ctrl_q     <= '0;
      branch_taken_q <= 1'b0;
      done_q         <= 1'b0;
      done_pend_q    <= 1'b0;
      illegal_op_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      acc_q          <= acc_d;
      alu_acc_q      <= alu_acc_d;
      alu_data_q     <= alu_data_d;
      alu_ctrl_q     <= alu_ctrl_d;
      branch_taken_q <= branch_taken_d;
      done_q         <= done_d;
      done_pend_q    <= done_pend_d;
      illegal_op_q   <= illegal_op_d;
    end
  end

`ifdef ACC_SEQ_ZFLAG_EN
  logic zero_flag_q, zero_flag_d;

  always_comb begin
    zero_flag_d = zero_flag_q;
    if (acc_we) zero_flag_d = (acc_d == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) zero_flag_q <= (ACC_RESET == '0);
    else       zero_flag_q <= zero_flag_d;
  end

  assign zero_flag = zero_flag_q;
`endif

  assign acc          = acc_q;
  assign alu_acc      = alu_acc_q;
  assign alu_data     = alu_data_q;
  assign alu_ctrl     = alu_ctrl_q;
  assign branch_taken = branch_taken_q;
  assign done         = done_q;
  assign illegal_op   = illegal_op_q;

endmodule
